// File: rtl/alu_operand_stage.sv
// ID->EX operand stage: registers decoded instruction fields, decodes ALU control,
// and forwards MEM/WB results onto the ALU operands and store data.
package alu_operand_stage_pkg;
    localparam int unsigned ALU_CTRL_W = 3;

    localparam logic [ALU_CTRL_W-1:0] ALU_AND = 3'd0;
    localparam logic [ALU_CTRL_W-1:0] ALU_OR  = 3'd1;
    localparam logic [ALU_CTRL_W-1:0] ALU_ADD = 3'd2;
    localparam logic [ALU_CTRL_W-1:0] ALU_OFF = 3'd3;
    localparam logic [ALU_CTRL_W-1:0] ALU_SUB = 3'd6;
    localparam logic [ALU_CTRL_W-1:0] ALU_SLT = 3'd7;
endpackage

module alu_operand_stage
    import alu_operand_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        flush,
    input  logic        id_valid,
    input  logic [31:0] id_rs_data,
    input  logic [31:0] id_rt_data,
    input  logic [31:0] id_imm,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic [4:0]  id_rd,
    input  logic [1:0]  id_alu_op,
    input  logic [5:0]  id_funct,
    input  logic        id_alu_src,
    input  logic        id_reg_dst,
    input  logic        id_reg_write,
    input  logic        mem_reg_write,
    input  logic        wb_reg_write,
    input  logic [4:0]  mem_rd,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] mem_result,
    input  logic [31:0] wb_result,
    output logic [31:0] a,
    output logic [31:0] b,
    output logic [2:0]  alu_ctrl,
    output logic        ex_valid,
    output logic        ex_reg_write,
    output logic [4:0]  ex_wr_reg,
    output logic [31:0] ex_store_data
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned REG_W  = 5;

    logic [DATA_W-1:0]     rs_data_q, rt_data_q, imm_q;
    logic [REG_W-1:0]      rs_q, rt_q, wr_reg_q;
    logic                  alu_src_q, reg_write_q, valid_q;
    logic [ALU_CTRL_W-1:0] alu_ctrl_q;
    logic [ALU_CTRL_W-1:0] dec_ctrl;
    logic [DATA_W-1:0]     fwd_rs, fwd_rt;

    // ALU control decode from the main-decoder class and R-type funct
    always_comb begin
        dec_ctrl = ALU_OFF;
        case (id_alu_op)
            2'b00: dec_ctrl = ALU_ADD;
            2'b01: dec_ctrl = ALU_SUB;
            2'b10: begin
                case (id_funct)
                    6'b100000: dec_ctrl = ALU_ADD;
                    6'b100010: dec_ctrl = ALU_SUB;
                    6'b100100: dec_ctrl = ALU_AND;
                    6'b100101: dec_ctrl = ALU_OR;
                    6'b101010: dec_ctrl = ALU_SLT;
                    default:   dec_ctrl = ALU_OFF;
                endcase
            end
            default: dec_ctrl = ALU_OFF;
        endcase
    end

    // Stage registers: flush beats stall beats capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rs_data_q   <= '0;
            rt_data_q   <= '0;
            imm_q       <= '0;
            rs_q        <= '0;
            rt_q        <= '0;
            wr_reg_q    <= '0;
            alu_src_q   <= 1'b0;
            reg_write_q <= 1'b0;
            valid_q     <= 1'b0;
            alu_ctrl_q  <= ALU_OFF;
        end else if (flush) begin
            valid_q     <= 1'b0;
            reg_write_q <= 1'b0;
            alu_ctrl_q  <= ALU_OFF;
        end else if (!stall) begin
            rs_data_q   <= id_rs_data;
            rt_data_q   <= id_rt_data;
            imm_q       <= id_imm;
            rs_q        <= id_rs;
            rt_q        <= id_rt;
            wr_reg_q    <= id_reg_dst ? id_rd : id_rt;
            alu_src_q   <= id_alu_src;
            reg_write_q <= id_reg_write & id_valid;
            valid_q     <= id_valid;
            alu_ctrl_q  <= dec_ctrl;
        end
    end

    // Forwarding: MEM over WB, register 0 never forwarded
    always_comb begin
        fwd_rs = rs_data_q;
        if (mem_reg_write && (mem_rd != '0) && (mem_rd == rs_q)) begin
            fwd_rs = mem_result;
        end else if (wb_reg_write && (wb_rd != '0) && (wb_rd == rs_q)) begin
            fwd_rs = wb_result;
        end
        fwd_rt = rt_data_q;
        if (mem_reg_write && (mem_rd != '0) && (mem_rd == rt_q)) begin
            fwd_rt = mem_result;
        end else if (wb_reg_write && (wb_rd != '0) && (wb_rd == rt_q)) begin
            fwd_rt = wb_result;
        end
    end

    // Operand outputs, quiet while the stage holds a bubble
    always_comb begin
        a             = valid_q ? fwd_rs : '0;
        b             = valid_q ? (alu_src_q ? imm_q : fwd_rt) : '0;
        alu_ctrl      = valid_q ? alu_ctrl_q : ALU_OFF;
        ex_valid      = valid_q;
        ex_reg_write  = valid_q & reg_write_q;
        ex_wr_reg     = wr_reg_q;
        ex_store_data = fwd_rt;
    end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Randomized self-checking bench for alu_operand_stage against an
// instruction-level reference model of the ID->EX stage.
module tb_alu_operand_stage;
    import alu_operand_stage_pkg::*;

    logic        clk, rst_n, stall, flush, id_valid;
    logic [31:0] id_rs_data, id_rt_data, id_imm;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic [1:0]  id_alu_op;
    logic [5:0]  id_funct;
    logic        id_alu_src, id_reg_dst, id_reg_write;
    logic        mem_reg_write, wb_reg_write;
    logic [4:0]  mem_rd, wb_rd;
    logic [31:0] mem_result, wb_result;
    logic [31:0] a, b, ex_store_data;
    logic [2:0]  alu_ctrl;
    logic        ex_valid, ex_reg_write;
    logic [4:0]  ex_wr_reg;

    int errors = 0;
    int checks = 0;

    alu_operand_stage dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .id_valid(id_valid), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
        .id_imm(id_imm), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_alu_op(id_alu_op), .id_funct(id_funct), .id_alu_src(id_alu_src),
        .id_reg_dst(id_reg_dst), .id_reg_write(id_reg_write),
        .mem_reg_write(mem_reg_write), .wb_reg_write(wb_reg_write),
        .mem_rd(mem_rd), .wb_rd(wb_rd), .mem_result(mem_result), .wb_result(wb_result),
        .a(a), .b(b), .alu_ctrl(alu_ctrl), .ex_valid(ex_valid),
        .ex_reg_write(ex_reg_write), .ex_wr_reg(ex_wr_reg), .ex_store_data(ex_store_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The instruction currently sitting in EX, as the model sees it
    typedef struct {
        bit        valid;
        bit        known;
        bit [31:0] rs_data, rt_data, imm;
        bit [4:0]  rs, rt, dest;
        bit        alu_src, writes;
        bit [2:0]  op;
    } ex_instr_t;

    ex_instr_t m;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit [2:0] ref_op(bit [1:0] op, bit [5:0] fn);
        if (op == 2'b00) return ALU_ADD;
        if (op == 2'b01) return ALU_SUB;
        if (op == 2'b11) return ALU_OFF;
        if (fn == 6'b100000) return ALU_ADD;
        if (fn == 6'b100010) return ALU_SUB;
        if (fn == 6'b100100) return ALU_AND;
        if (fn == 6'b100101) return ALU_OR;
        if (fn == 6'b101010) return ALU_SLT;
        return ALU_OFF;
    endfunction

    function automatic bit [31:0] ref_fwd(bit [4:0] r, bit [31:0] rf);
        if (r == 0) return rf;
        if (mem_reg_write && mem_rd == r) return mem_result;
        if (wb_reg_write && wb_rd == r) return wb_result;
        return rf;
    endfunction

    task automatic model_reset();
        m = '{default: 0};
        m.op = ALU_OFF;
        m.known = 1;
    endtask

    // Apply what the next rising edge will do to the EX instruction
    task automatic model_edge();
        if (flush) begin
            m.valid = 0; m.writes = 0; m.op = ALU_OFF; m.known = 0;
        end else if (!stall) begin
            m.valid = id_valid; m.known = 1;
            m.rs_data = id_rs_data; m.rt_data = id_rt_data; m.imm = id_imm;
            m.rs = id_rs; m.rt = id_rt; m.dest = id_reg_dst ? id_rd : id_rt;
            m.alu_src = id_alu_src; m.writes = id_reg_write && id_valid;
            m.op = ref_op(id_alu_op, id_funct);
        end
    endtask

    task automatic check_all(input string tag);
        bit [31:0] rt_val;
        rt_val = ref_fwd(m.rt, m.rt_data);
        check({tag, ".a"}, a, m.valid ? ref_fwd(m.rs, m.rs_data) : 32'h0);
        check({tag, ".b"}, b, m.valid ? (m.alu_src ? m.imm : rt_val) : 32'h0);
        check({tag, ".ctrl"}, 32'(alu_ctrl), 32'(m.valid ? m.op : ALU_OFF));
        check({tag, ".valid"}, 32'(ex_valid), 32'(m.valid));
        check({tag, ".rw"}, 32'(ex_reg_write), 32'(m.valid && m.writes));
        if (m.known) begin
            check({tag, ".wr"}, 32'(ex_wr_reg), 32'(m.dest));
            check({tag, ".sd"}, ex_store_data, rt_val);
        end
    endtask

    task automatic cycle(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic set_id(input logic v, input logic [31:0] rsd, input logic [31:0] rtd,
                          input logic [31:0] imm, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [1:0] op, input logic [5:0] fn, input logic src);
        id_valid = v; id_rs_data = rsd; id_rt_data = rtd; id_imm = imm;
        id_rs = rs; id_rt = rt; id_rd = 5'd9; id_alu_op = op; id_funct = fn;
        id_alu_src = src; id_reg_dst = 1'b1; id_reg_write = 1'b1;
    endtask

    task automatic no_fwd();
        mem_reg_write = 0; wb_reg_write = 0; mem_rd = 0; wb_rd = 0;
        mem_result = 32'hDEAD_0001; wb_result = 32'hDEAD_0002;
    endtask

    task automatic rand_id();
        logic [5:0] fns [6];
        fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000000};
        id_valid = ($urandom_range(0, 3) != 0);
        id_rs_data = $urandom; id_rt_data = $urandom; id_imm = $urandom;
        id_rs = 5'($urandom_range(0, 7)); id_rt = 5'($urandom_range(0, 7));
        id_rd = 5'($urandom);
        id_alu_op = 2'($urandom);
        id_funct = ($urandom_range(0, 3) == 0) ? 6'($urandom) : fns[$urandom_range(0, 5)];
        id_alu_src = 1'($urandom); id_reg_dst = 1'($urandom); id_reg_write = 1'($urandom);
    endtask

    task automatic rand_fwd();
        mem_reg_write = 1'($urandom); wb_reg_write = 1'($urandom);
        mem_rd = 5'($urandom_range(0, 7)); wb_rd = 5'($urandom_range(0, 7));
        mem_result = $urandom; wb_result = $urandom;
    endtask

    logic [31:0] snap_a, snap_b, snap_sd;

    initial begin
        rst_n = 0; stall = 0; flush = 0;
        set_id(0, 0, 0, 0, 0, 0, 2'b00, 6'd0, 0);
        no_fwd();
        model_reset();
        #12;
        check_all("reset");
        check("reset.ctrl_off", 32'(alu_ctrl), 32'(ALU_OFF));
        rst_n = 1;
        #3;

        // R-type add, no hazards
        set_id(1, 32'd8, 32'd41, 32'h0, 5'd1, 5'd2, 2'b10, 6'b100000, 0);
        cycle("radd");
        check("radd.a8", a, 32'd8);
        check("radd.b41", b, 32'd41);
        check("radd.add", 32'(alu_ctrl), 32'(ALU_ADD));

        // Immediate operand
        set_id(1, 32'd3, 32'h1234, 32'hFFFF_FFFC, 5'd1, 5'd2, 2'b00, 6'd0, 1);
        cycle("imm");
        check("imm.b", b, 32'hFFFF_FFFC);
        check("imm.sd", ex_store_data, 32'h1234);

        // Forwarding priority and mid-cycle update
        set_id(1, 32'h55, 32'h66, 32'h0, 5'd5, 5'd6, 2'b00, 6'd0, 0);
        cycle("fwd_cap");
        mem_reg_write = 1; mem_rd = 5'd5; mem_result = 32'h11;
        wb_reg_write = 1; wb_rd = 5'd5; wb_result = 32'h22;
        #1; check_all("fwd_mem"); check("fwd_mem.a", a, 32'h11);
        mem_reg_write = 0;
        #1; check_all("fwd_wb"); check("fwd_wb.a", a, 32'h22);
        mem_reg_write = 1; mem_rd = 5'd0; wb_rd = 5'd0;
        set_id(1, 32'h33, 32'h44, 32'h0, 5'd0, 5'd0, 2'b00, 6'd0, 0);
        cycle("fwd_r0"); check("fwd_r0.a", a, 32'h33);
        no_fwd();

        // Stall holds outputs while ID inputs churn
        #1; snap_a = a; snap_b = b; snap_sd = ex_store_data;
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            rand_id();
            cycle("stall");
            check("stall.a_hold", a, snap_a);
            check("stall.b_hold", b, snap_b);
            check("stall.sd_hold", ex_store_data, snap_sd);
        end
        flush = 1;
        cycle("flush_stall");
        check("flush.a0", a, 32'h0);
        check("flush.off", 32'(alu_ctrl), 32'(ALU_OFF));
        stall = 0; flush = 0;

        // Unknown funct
        set_id(1, 32'h7, 32'h8, 32'h0, 5'd1, 5'd2, 2'b10, 6'b000111, 0);
        cycle("badfn");
        check("badfn.off", 32'(alu_ctrl), 32'(ALU_OFF));

        // Asynchronous reset between edges, asserted over stall and flush
        set_id(1, 32'hA, 32'hB, 32'hC, 5'd3, 5'd4, 2'b01, 6'd0, 0);
        cycle("pre_rst");
        #2; rst_n = 0; stall = 1; flush = 1;
        model_reset();
        #1; check_all("async_rst");
        @(posedge clk); #2;
        check_all("rst_hold");
        rst_n = 1; stall = 0; flush = 0;
        set_id(1, 32'h21, 32'h22, 32'h0, 5'd3, 5'd4, 2'b01, 6'd0, 0);
        cycle("post_rst");

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            rand_id();
            stall = ($urandom_range(0, 5) == 0);
            flush = ($urandom_range(0, 7) == 0);
            rand_fwd();
            cycle("rnd");
            rand_fwd();
            #1; check_all("rnd_mid");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
